// File: rtl/encoder4_2_behavioral.sv
// Registered 4-to-2 encoder with valid and error flags.
// Define ENC_PRIORITY_EN to resolve multi-hot requests by highest index instead of flagging an error.
module encoder4_2_behavioral #(
  parameter int ERR_STICKY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic Y3,
  input  logic Y2,
  input  logic Y1,
  input  logic Y0,
  output logic A1,
  output logic A0,
  output logic V,
  output logic E
);

  logic [3:0] req;
  logic       multi_hot;
  logic [1:0] next_a;
  logic       next_v;
  logic       next_err;

  assign req = {Y3, Y2, Y1, Y0};

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = |(req & (req - 4'd1));

  always_comb begin
    next_a   = '0;
    next_v   = 1'b0;
    next_err = 1'b0;
    if (en) begin
`ifdef ENC_PRIORITY_EN
      casez (req)
        4'b1???: begin next_a = 2'b11; next_v = 1'b1; end
        4'b01??: begin next_a = 2'b10; next_v = 1'b1; end
        4'b001?: begin next_a = 2'b01; next_v = 1'b1; end
        4'b0001: begin next_a = 2'b00; next_v = 1'b1; end
        default: begin next_a = 2'b00; next_v = 1'b0; end
      endcase
`else
      if (multi_hot) begin
        next_err = 1'b1;
      end else begin
        unique case (req)
          4'b1000: begin next_a = 2'b11; next_v = 1'b1; end
          4'b0100: begin next_a = 2'b10; next_v = 1'b1; end
          4'b0010: begin next_a = 2'b01; next_v = 1'b1; end
          4'b0001: begin next_a = 2'b00; next_v = 1'b1; end
          default: begin next_a = 2'b00; next_v = 1'b0; end
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A1 <= 1'b0;
      A0 <= 1'b0;
      V  <= 1'b0;
      E  <= 1'b0;
    end else begin
      A1 <= next_a[1];
      A0 <= next_a[0];
      V  <= next_v;
      E  <= next_err | ((ERR_STICKY != 0) & E);
    end
  end

endmodule

// File: tb/tb_encoder4_2_behavioral.sv
// Directed bench for encoder4_2_behavioral: a non-sticky and a sticky instance share stimulus.
`timescale 1ns/100ps
module tb_encoder4_2_behavioral;

  logic clk = 1'b0;
  logic rst, en, Y3, Y2, Y1, Y0;
  logic n_a1, n_a0, n_v, n_e;
  logic s_a1, s_a0, s_v, s_e;
  int   checks = 0;
  int   failures = 0;

`ifdef ENC_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  always #12.5 clk = ~clk;

  encoder4_2_behavioral u_norm (
    .clk(clk), .rst(rst), .en(en),
    .Y3(Y3), .Y2(Y2), .Y1(Y1), .Y0(Y0),
    .A1(n_a1), .A0(n_a0), .V(n_v), .E(n_e)
  );

  encoder4_2_behavioral #(.ERR_STICKY(1)) u_sticky (
    .clk(clk), .rst(rst), .en(en),
    .Y3(Y3), .Y2(Y2), .Y1(Y1), .Y0(Y0),
    .A1(s_a1), .A0(s_a0), .V(s_v), .E(s_e)
  );

  task automatic drive(input logic r, input logic e, input logic [3:0] y);
    rst = r;
    en  = e;
    {Y3, Y2, Y1, Y0} = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected values are packed as {A1,A0,V,E}.
  task automatic check(input string tag, input logic [3:0] exp_n, input logic [3:0] exp_s);
    checks++;
    assert ({n_a1, n_a0, n_v, n_e} === exp_n)
      else begin
        failures++;
        $error("FAIL %s norm: got %b expected %b", tag, {n_a1, n_a0, n_v, n_e}, exp_n);
      end
    checks++;
    assert ({s_a1, s_a0, s_v, s_e} === exp_s)
      else begin
        failures++;
        $error("FAIL %s sticky: got %b expected %b", tag, {s_a1, s_a0, s_v, s_e}, exp_s);
      end
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'b0000);
    tick();
    tick();
    check("reset", 4'b0000, 4'b0000);

    drive(1'b0, 1'b0, 4'b0100);
    tick();
    check("en_low", 4'b0000, 4'b0000);

    drive(1'b0, 1'b1, 4'b1000);
    tick();
    check("y3", 4'b1110, 4'b1110);
    drive(1'b0, 1'b1, 4'b0100);
    tick();
    check("y2", 4'b1010, 4'b1010);
    drive(1'b0, 1'b1, 4'b0010);
    tick();
    check("y1", 4'b0110, 4'b0110);
    drive(1'b0, 1'b1, 4'b0001);
    tick();
    check("y0", 4'b0010, 4'b0010);

    // Inputs glitch between edges but settle back before the next edge.
    #5 {Y3, Y2, Y1, Y0} = 4'b1111;
    #3 {Y3, Y2, Y1, Y0} = 4'b0001;
    tick();
    check("glitch", 4'b0010, 4'b0010);

    drive(1'b0, 1'b1, 4'b0000);
    tick();
    check("none", 4'b0000, 4'b0000);

    drive(1'b0, 1'b1, 4'b1010);
    tick();
    check("multi_1010", PRIO ? 4'b1110 : 4'b0001, PRIO ? 4'b1110 : 4'b0001);

    drive(1'b0, 1'b1, 4'b0010);
    tick();
    check("after_multi", 4'b0110, PRIO ? 4'b0110 : 4'b0111);

    drive(1'b0, 1'b0, 4'b1111);
    tick();
    check("en_low_sticky", 4'b0000, PRIO ? 4'b0000 : 4'b0001);

    drive(1'b1, 1'b1, 4'b0000);
    tick();
    check("clear_sticky", 4'b0000, 4'b0000);

    drive(1'b0, 1'b1, 4'b0110);
    tick();
    check("multi_0110", PRIO ? 4'b1010 : 4'b0001, PRIO ? 4'b1010 : 4'b0001);
    drive(1'b0, 1'b1, 4'b0010);
    tick();
    check("sticky_hold", 4'b0110, PRIO ? 4'b0110 : 4'b0111);

    drive(1'b0, 1'b1, 4'b0101);
    tick();
    check("multi_0101", PRIO ? 4'b1010 : 4'b0001, PRIO ? 4'b1010 : 4'b0001);
    drive(1'b0, 1'b1, 4'b0011);
    tick();
    check("multi_0011", PRIO ? 4'b0110 : 4'b0001, PRIO ? 4'b0110 : 4'b0001);
    drive(1'b0, 1'b1, 4'b1111);
    tick();
    check("multi_1111", PRIO ? 4'b1110 : 4'b0001, PRIO ? 4'b1110 : 4'b0001);

    drive(1'b1, 1'b1, 4'b1000);
    tick();
    check("rst_priority", 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, 4'b1000);
    tick();
    check("post_rst", 4'b1110, 4'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder4_2_behavioral.md
ENCODER4_2_BEHAVIORAL -- requirements
Module: encoder4_2_behavioral

Interface
REQ-001 Parameter ERR_STICKY, default 0, selects error-flag behaviour:
- 0: E is recomputed every cycle.
- 1: E, once set, holds until reset.

REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  encoder enable; active-high.
REQ-005 Y3  input  1  request line 3 (highest index).
REQ-006 Y2  input  1  request line 2.
REQ-007 Y1  input  1  request line 1.
REQ-008 Y0  input  1  request line 0 (lowest index).
REQ-009 A1  output  1  encoded index, MSB; registered.
REQ-010 A0  output  1  encoded index, LSB; registered.
REQ-011 V  output  1  valid: {A1,A0} holds a legal encoding of a request; registered.
REQ-012 E  output  1  error: illegal multi-hot request seen; registered.

Function
REQ-013 All outputs are registered; latency is exactly 1 clk from sampled inputs to outputs; no combinational input-to-output path.
REQ-014 en=0 on a rising edge: next cycle {A1,A0}=00, V=0, E=0 (E held instead if ERR_STICKY=1 and already set), regardless of Y3..Y0.
REQ-015 en=1 with exactly one Yi=1:
- {A1,A0}=i in binary: Y3 gives 11, Y2 gives 10, Y1 gives 01, Y0 gives 00.
- V=1.
- E=0, unless sticky and already set.
REQ-016 en=1 with all Y=0: {A1,A0}=00, V=0, E=0 (unless sticky); distinguishes "no request" from "Y0 request" through V only.
REQ-017 en=1 with two or more Yi=1: behaviour set by the Configuration section.
REQ-018 Inputs are sampled only on rising clk edges; changes between edges have no effect.
REQ-019 Outputs change only on rising clk edges.
REQ-020 ERR_STICKY=1: E set by a multi-hot event stays 1 through en=0 and through later legal inputs, until rst. A1, A0 and V still follow REQ-014 to REQ-017 every cycle.
REQ-021 X or Z on any Y while en=1 does not need defined outputs; the bench drives only 0/1.

Reset
REQ-022 rst=1 at a rising edge forces {A1,A0}=00, V=0, E=0 on that edge, including a sticky E.
REQ-023 rst has priority over en and Y inputs; asserting rst mid-operation discards the pending encoding.
REQ-024 First cycle after rst deasserts: outputs reflect inputs sampled at that edge, per REQ-013.

Configuration
REQ-025 Macro ENC_PRIORITY_EN selects the multi-hot handling.
REQ-026 ENC_PRIORITY_EN defined, multi-hot with en=1:
- Highest asserted index wins (e.g. Y3=1,Y1=1 gives 11; Y2=1,Y0=1 gives 10).
- V=1, E=0 (sticky E retained).
REQ-027 ENC_PRIORITY_EN undefined, multi-hot with en=1:
- {A1,A0}=00, V=0, E=1.
- With ERR_STICKY=1, E then latches per REQ-020.
REQ-028 Single-hot and zero-hot behaviour is identical in both builds.

Verification
REQ-029 rst=1 for 2 cycles, then en=0,Y=0100 -> A=00, V=0, E=0 one cycle later.
REQ-030 en=1, successive single-hot inputs, each held 25 ns -> 1 clk later:
- Y=1000 gives A=11, V=1.
- Y=0100 gives A=10, V=1.
- Y=0010 gives A=01, V=1.
- Y=0001 gives A=00, V=1.
REQ-031 en=1, Y=0000 -> A=00, V=0, E=0.
REQ-032 en=1, Y=1010:
- With ENC_PRIORITY_EN: A=11, V=1, E=0.
- Without it: A=00, V=0, E=1.
REQ-033 ERR_STICKY=1, ENC_PRIORITY_EN undefined: Y=0110 then Y=0010 -> E stays 1 while A=01, V=1; rst=1 -> E=0 next edge.
REQ-034 en=1, Y=1000 with rst asserted the same edge -> A=00, V=0; rst released -> A=11, V=1 one cycle later.
